// File: rtl/axi_rr_arbiter_if.sv
// AXI4 bundle shared by both upstream masters and the downstream port.
// The master modport drives requests; the slave modport answers them.
`timescale 1ns/1ps
interface axi_rr_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wid, wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wid, wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready
  );
endinterface

// File: rtl/axi_rr_arbiter.sv
// Two-master to one-slave AXI4 arbiter: instruction fetch (m0) and load/store
// (m1) share one downstream port. Read and write channels arbitrate separately
// with round-robin priority and hold the grant from address to last response.
// The slave wlast is generated from the beat count against the accepted awlen,
// so a master that raises wlast early or late cannot shorten or stretch a burst.
`timescale 1ns/1ps
module axi_rr_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  axi_rr_arbiter_if.slave  m0,
  axi_rr_arbiter_if.slave  m1,
  axi_rr_arbiter_if.master s
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

  r_state_t   r_state, r_next;
  w_state_t   w_state, w_next;
  logic       rgrant, rgrant_next, rprio, rprio_next;
  logic       wgrant, wgrant_next, wprio, wprio_next;
  logic [7:0] wcnt, wcnt_next, awlen_q, awlen_next;

  // Read and write state registers; reset returns both channels to idle with m0 preferred.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= R_IDLE;
      rgrant  <= 1'b0;
      rprio   <= 1'b0;
      w_state <= W_IDLE;
      wgrant  <= 1'b0;
      wprio   <= 1'b0;
      wcnt    <= 8'd0;
      awlen_q <= 8'd0;
    end else begin
      r_state <= r_next;
      rgrant  <= rgrant_next;
      rprio   <= rprio_next;
      w_state <= w_next;
      wgrant  <= wgrant_next;
      wprio   <= wprio_next;
      wcnt    <= wcnt_next;
      awlen_q <= awlen_next;
    end
  end

  // Read channel: arbitration, AR/R routing by grant; everything quiet while in reset.
  always_comb begin
    r_next      = r_state;
    rgrant_next = rgrant;
    rprio_next  = rprio;
    s.arid      = {ID_W{1'b0}};
    s.araddr    = {ADDR_W{1'b0}};
    s.arlen     = 8'd0;
    s.arsize    = 3'd0;
    s.arburst   = 2'd0;
    s.arvalid   = 1'b0;
    s.rready    = 1'b0;
    m0.arready  = 1'b0;
    m0.rid      = {ID_W{1'b0}};
    m0.rdata    = {DATA_W{1'b0}};
    m0.rresp    = 2'd0;
    m0.rlast    = 1'b0;
    m0.rvalid   = 1'b0;
    m1.arready  = 1'b0;
    m1.rid      = {ID_W{1'b0}};
    m1.rdata    = {DATA_W{1'b0}};
    m1.rresp    = 2'd0;
    m1.rlast    = 1'b0;
    m1.rvalid   = 1'b0;
    if (!rst_i) begin
      unique case (r_state)
        R_IDLE: begin
          if (m0.arvalid || m1.arvalid) begin
            rgrant_next = (m0.arvalid && m1.arvalid) ? rprio : m1.arvalid;
            r_next      = R_ADDR;
          end
        end
        R_ADDR: begin
          if (rgrant) begin
            s.arid     = m1.arid;
            s.araddr   = m1.araddr;
            s.arlen    = m1.arlen;
            s.arsize   = m1.arsize;
            s.arburst  = m1.arburst;
            s.arvalid  = m1.arvalid;
            m1.arready = s.arready;
          end else begin
            s.arid     = m0.arid;
            s.araddr   = m0.araddr;
            s.arlen    = m0.arlen;
            s.arsize   = m0.arsize;
            s.arburst  = m0.arburst;
            s.arvalid  = m0.arvalid;
            m0.arready = s.arready;
          end
          if (s.arvalid && s.arready) r_next = R_DATA;
        end
        R_DATA: begin
          if (rgrant) begin
            m1.rid    = s.rid;
            m1.rdata  = s.rdata;
            m1.rresp  = s.rresp;
            m1.rlast  = s.rlast;
            m1.rvalid = s.rvalid;
            s.rready  = m1.rready;
          end else begin
            m0.rid    = s.rid;
            m0.rdata  = s.rdata;
            m0.rresp  = s.rresp;
            m0.rlast  = s.rlast;
            m0.rvalid = s.rvalid;
            s.rready  = m0.rready;
          end
          if (s.rvalid && s.rready && s.rlast) begin
            r_next     = R_IDLE;
            rprio_next = ~rgrant;
          end
        end
        default: r_next = R_IDLE;
      endcase
    end
  end

  // Write channel: arbitration, AW then W then B routing, and beat counting for slave wlast.
  always_comb begin
    w_next      = w_state;
    wgrant_next = wgrant;
    wprio_next  = wprio;
    wcnt_next   = wcnt;
    awlen_next  = awlen_q;
    s.awid      = {ID_W{1'b0}};
    s.awaddr    = {ADDR_W{1'b0}};
    s.awlen     = 8'd0;
    s.awsize    = 3'd0;
    s.awburst   = 2'd0;
    s.awvalid   = 1'b0;
    s.wid       = {ID_W{1'b0}};
    s.wdata     = {DATA_W{1'b0}};
    s.wstrb     = {(DATA_W/8){1'b0}};
    s.wlast     = 1'b0;
    s.wvalid    = 1'b0;
    s.bready    = 1'b0;
    m0.awready  = 1'b0;
    m0.wready   = 1'b0;
    m0.bid      = {ID_W{1'b0}};
    m0.bresp    = 2'd0;
    m0.bvalid   = 1'b0;
    m1.awready  = 1'b0;
    m1.wready   = 1'b0;
    m1.bid      = {ID_W{1'b0}};
    m1.bresp    = 2'd0;
    m1.bvalid   = 1'b0;
    if (!rst_i) begin
      unique case (w_state)
        W_IDLE: begin
          if (m0.awvalid || m1.awvalid) begin
            wgrant_next = (m0.awvalid && m1.awvalid) ? wprio : m1.awvalid;
            wcnt_next   = 8'd0;
            w_next      = W_ADDR;
          end
        end
        W_ADDR: begin
          if (wgrant) begin
            s.awid     = m1.awid;
            s.awaddr   = m1.awaddr;
            s.awlen    = m1.awlen;
            s.awsize   = m1.awsize;
            s.awburst  = m1.awburst;
            s.awvalid  = m1.awvalid;
            m1.awready = s.awready;
          end else begin
            s.awid     = m0.awid;
            s.awaddr   = m0.awaddr;
            s.awlen    = m0.awlen;
            s.awsize   = m0.awsize;
            s.awburst  = m0.awburst;
            s.awvalid  = m0.awvalid;
            m0.awready = s.awready;
          end
          if (s.awvalid && s.awready) begin
            awlen_next = s.awlen;
            w_next     = W_DATA;
          end
        end
        W_DATA: begin
          if (wgrant) begin
            s.wid     = m1.wid;
            s.wdata   = m1.wdata;
            s.wstrb   = m1.wstrb;
            s.wvalid  = m1.wvalid;
            m1.wready = s.wready;
          end else begin
            s.wid     = m0.wid;
            s.wdata   = m0.wdata;
            s.wstrb   = m0.wstrb;
            s.wvalid  = m0.wvalid;
            m0.wready = s.wready;
          end
          s.wlast = (wcnt == awlen_q);
          if (s.wvalid && s.wready) begin
            wcnt_next = wcnt + 8'd1;
            if (s.wlast) w_next = W_RESP;
          end
        end
        W_RESP: begin
          if (wgrant) begin
            m1.bid    = s.bid;
            m1.bresp  = s.bresp;
            m1.bvalid = s.bvalid;
            s.bready  = m1.bready;
          end else begin
            m0.bid    = s.bid;
            m0.bresp  = s.bresp;
            m0.bvalid = s.bvalid;
            s.bready  = m0.bready;
          end
          if (s.bvalid && s.bready) begin
            w_next     = W_IDLE;
            wprio_next = ~wgrant;
          end
        end
        default: w_next = W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Bench for axi_rr_arbiter: a read-channel vector table for single reads and
// round-robin alternation, then hand sequences for concurrent read/write,
// wlast forcing, address stall and reset in the middle of a burst.
`timescale 1ns/1ps
module tb_axi_rr_arbiter;

  localparam logic [31:0] A0 = 32'h3000_0000;
  localparam logic [31:0] A1 = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  axi_rr_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) m0_bus ();
  axi_rr_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) m1_bus ();
  axi_rr_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) s_bus ();

  axi_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus)
  );

  always #5 clk = ~clk;

  // One row per cycle of the read channel; flags are
  // {s_arvalid, m0_arready, m1_arready, s_rready, m0_rvalid, m1_rvalid}.
  typedef struct {
    logic        rst;
    logic        m0_arv;
    logic        m1_arv;
    logic        s_rv;
    logic        s_rl;
    logic [31:0] rdata;
    logic [5:0]  exp_flags;
    logic [31:0] exp_araddr;
    logic [31:0] exp_m0_rdata;
    logic [31:0] exp_m1_rdata;
  } rvec_t;

  rvec_t vecs[$];

  function automatic rvec_t rv(input logic r, input logic a0, input logic a1,
                               input logic srv, input logic srl, input logic [31:0] rd,
                               input logic [5:0] fl, input logic [31:0] ea,
                               input logic [31:0] e0, input logic [31:0] e1);
    rvec_t v;
    v.rst = r; v.m0_arv = a0; v.m1_arv = a1; v.s_rv = srv; v.s_rl = srl; v.rdata = rd;
    v.exp_flags = fl; v.exp_araddr = ea; v.exp_m0_rdata = e0; v.exp_m1_rdata = e1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input rvec_t v);
    rst            = v.rst;
    m0_bus.arvalid = v.m0_arv;
    m1_bus.arvalid = v.m1_arv;
    s_bus.rvalid   = v.s_rv;
    s_bus.rlast    = v.s_rl;
    s_bus.rdata    = v.rdata;
  endtask

  // m1 write burst of len+1 beats; hold_last keeps master wlast high on every beat.
  task automatic do_write(input logic [7:0] len, input logic hold_last,
                          input logic [31:0] addr, input logic [3:0] id);
    step();
    m1_bus.awvalid = 1'b1; m1_bus.awaddr = addr; m1_bus.awlen = len; m1_bus.awid = id;
    @(negedge clk);
    checkOutput("aw_idle", {s_bus.awvalid, m1_bus.awready}, 2'b00);
    step();
    @(negedge clk);
    checkOutput("aw_route", {s_bus.awvalid, m1_bus.awready, m0_bus.awready}, 3'b110);
    checkOutput("s_awaddr", s_bus.awaddr, addr);
    checkOutput("s_awlen", s_bus.awlen, len);
    for (int i = 0; i <= int'(len); i++) begin
      step();
      m1_bus.awvalid = 1'b0;
      m1_bus.wvalid  = 1'b1;
      m1_bus.wdata   = 32'hB000_0000 + i;
      m1_bus.wstrb   = 4'hF;
      m1_bus.wlast   = hold_last || (i == int'(len));
      @(negedge clk);
      checkOutput("w_beat", {s_bus.wvalid, s_bus.wlast, m1_bus.wready, m0_bus.wready, s_bus.wstrb},
                  {1'b1, (i == int'(len)), 1'b1, 1'b0, 4'hF});
      checkOutput("s_wdata", s_bus.wdata, 32'hB000_0000 + i);
    end
    step();
    m1_bus.wvalid = 1'b1; m1_bus.wlast = 1'b1;
    s_bus.bvalid = 1'b1; s_bus.bresp = 2'b00; s_bus.bid = id;
    @(negedge clk);
    checkOutput("w_held_off", {s_bus.wvalid, m1_bus.wready}, 2'b00);
    checkOutput("b_route", {m1_bus.bvalid, m0_bus.bvalid, s_bus.bready}, 3'b101);
    checkOutput("m1_bid_bresp", {m1_bus.bid, m1_bus.bresp}, {id, 2'b00});
    step();
    m1_bus.wvalid = 1'b0; s_bus.bvalid = 1'b0;
    @(negedge clk);
    checkOutput("w_idle", {s_bus.awvalid, s_bus.wvalid, s_bus.bready, m1_bus.bvalid}, 4'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic g;
    logic [31:0] d;

    m0_bus.arid = 4'h1; m0_bus.araddr = A0; m0_bus.arlen = 8'd0; m0_bus.arsize = 3'd2;
    m0_bus.arburst = 2'b01; m0_bus.arvalid = 1'b0; m0_bus.rready = 1'b1;
    m0_bus.awid = 4'h1; m0_bus.awaddr = 32'h0; m0_bus.awlen = 8'd0; m0_bus.awsize = 3'd2;
    m0_bus.awburst = 2'b01; m0_bus.awvalid = 1'b0; m0_bus.wid = 4'h1; m0_bus.wdata = 32'h0;
    m0_bus.wstrb = 4'h0; m0_bus.wlast = 1'b0; m0_bus.wvalid = 1'b0; m0_bus.bready = 1'b1;
    m1_bus.arid = 4'h3; m1_bus.araddr = A1; m1_bus.arlen = 8'd0; m1_bus.arsize = 3'd2;
    m1_bus.arburst = 2'b01; m1_bus.arvalid = 1'b0; m1_bus.rready = 1'b1;
    m1_bus.awid = 4'h3; m1_bus.awaddr = 32'h0; m1_bus.awlen = 8'd0; m1_bus.awsize = 3'd2;
    m1_bus.awburst = 2'b01; m1_bus.awvalid = 1'b0; m1_bus.wid = 4'h3; m1_bus.wdata = 32'h0;
    m1_bus.wstrb = 4'h0; m1_bus.wlast = 1'b0; m1_bus.wvalid = 1'b0; m1_bus.bready = 1'b1;
    s_bus.arready = 1'b1; s_bus.rid = 4'h0; s_bus.rdata = 32'h0; s_bus.rresp = 2'b00;
    s_bus.rlast = 1'b0; s_bus.rvalid = 1'b0; s_bus.awready = 1'b1; s_bus.wready = 1'b1;
    s_bus.bid = 4'h0; s_bus.bresp = 2'b00; s_bus.bvalid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Single m0 read, then reset and four tied rounds that must alternate m0, m1, m0, m1.
    vecs.push_back(rv(1, 0, 0, 0, 0, 32'h0,         6'b000000, 32'h0, 32'h0, 32'h0));
    vecs.push_back(rv(0, 1, 0, 0, 0, 32'h0,         6'b000000, 32'h0, 32'h0, 32'h0));
    vecs.push_back(rv(0, 1, 0, 0, 0, 32'h0,         6'b110000, A0,    32'h0, 32'h0));
    vecs.push_back(rv(0, 0, 0, 1, 1, 32'hDEADBEEF,  6'b000110, 32'h0, 32'hDEADBEEF, 32'h0));
    vecs.push_back(rv(0, 0, 0, 0, 0, 32'h0,         6'b000000, 32'h0, 32'h0, 32'h0));
    vecs.push_back(rv(1, 1, 1, 0, 0, 32'h0,         6'b000000, 32'h0, 32'h0, 32'h0));
    for (int k = 0; k < 4; k++) begin
      g = k[0];
      d = 32'h1111_1111 * (k + 1);
      vecs.push_back(rv(0, 1, 1, 0, 0, 32'h0, 6'b000000, 32'h0, 32'h0, 32'h0));
      vecs.push_back(rv(0, 1, 1, 0, 0, 32'h0, g ? 6'b101000 : 6'b110000, g ? A1 : A0, 32'h0, 32'h0));
      vecs.push_back(rv(0, 1, 1, 1, 1, d, g ? 6'b000101 : 6'b000110, 32'h0,
                        g ? 32'h0 : d, g ? d : 32'h0));
    end
    vecs.push_back(rv(0, 0, 0, 0, 0, 32'h0, 6'b000000, 32'h0, 32'h0, 32'h0));

    foreach (vecs[i]) begin
      step();
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_flags", i),
                  {s_bus.arvalid, m0_bus.arready, m1_bus.arready, s_bus.rready, m0_bus.rvalid, m1_bus.rvalid},
                  vecs[i].exp_flags);
      checkOutput($sformatf("vec%0d_araddr", i), s_bus.araddr, vecs[i].exp_araddr);
      checkOutput($sformatf("vec%0d_m0_rdata", i), m0_bus.rdata, vecs[i].exp_m0_rdata);
      checkOutput($sformatf("vec%0d_m1_rdata", i), m1_bus.rdata, vecs[i].exp_m1_rdata);
    end
    $display("[TB] read vector table done");

    // m1 4-beat write concurrent with an m0 single read.
    fork
      do_write(8'd3, 1'b0, 32'h5000_0000, 4'h5);
      begin
        step();
        m0_bus.arvalid = 1'b1; m0_bus.araddr = A0; m0_bus.arlen = 8'd0;
        @(negedge clk);
        checkOutput("conc_ar_idle", s_bus.arvalid, 1'b0);
        step();
        @(negedge clk);
        checkOutput("conc_ar_route", {s_bus.arvalid, m0_bus.arready}, 2'b11);
        step();
        m0_bus.arvalid = 1'b0;
        s_bus.rvalid = 1'b1; s_bus.rlast = 1'b1; s_bus.rdata = 32'hCAFE_0001; s_bus.rid = 4'h2;
        @(negedge clk);
        checkOutput("conc_r_route", {m0_bus.rvalid, m1_bus.rvalid, m0_bus.rlast}, 3'b101);
        checkOutput("conc_r_data", m0_bus.rdata, 32'hCAFE_0001);
        checkOutput("conc_r_id", m0_bus.rid, 4'h2);
        step();
        s_bus.rvalid = 1'b0; s_bus.rlast = 1'b0;
      end
    join

    // Master wlast early: slave wlast comes only on beat awlen+1.
    do_write(8'd1, 1'b1, 32'h5000_0100, 4'h6);
    do_write(8'd2, 1'b1, 32'h5000_0200, 4'h7);

    // Reset during beat 4 of an 8-beat m0 read (rprio is 1 going in).
    step();
    m0_bus.arvalid = 1'b1; m0_bus.arlen = 8'd7;
    step();
    @(negedge clk);
    checkOutput("rst_ar_route", {s_bus.arvalid, m0_bus.arready}, 2'b11);
    for (int b = 1; b <= 3; b++) begin
      step();
      m0_bus.arvalid = 1'b0;
      s_bus.rvalid = 1'b1; s_bus.rlast = 1'b0; s_bus.rdata = 32'hD000_0000 + b;
      @(negedge clk);
      checkOutput("rst_beat", {m0_bus.rvalid, s_bus.rready}, 2'b11);
      checkOutput("rst_beat_data", m0_bus.rdata, 32'hD000_0000 + b);
    end
    step();
    rst = 1'b1; s_bus.rdata = 32'hD000_0004;
    @(negedge clk);
    checkOutput("rst_cycle_quiet",
                {m0_bus.rvalid, m1_bus.rvalid, s_bus.rready, s_bus.arvalid, m0_bus.arready, m1_bus.arready},
                6'b000000);
    step();
    rst = 1'b0;
    m0_bus.arvalid = 1'b1; m0_bus.arlen = 8'd0; m1_bus.arvalid = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_quiet",
                {m0_bus.rvalid, m1_bus.rvalid, s_bus.rready, s_bus.arvalid, m0_bus.arready,
                 m1_bus.arready, s_bus.awvalid, s_bus.wvalid},
                8'h00);
    step();
    s_bus.rvalid = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_prio_m0", {s_bus.arvalid, m0_bus.arready, m1_bus.arready}, 3'b110);
    checkOutput("post_rst_araddr", s_bus.araddr, A0);
    step();
    m0_bus.arvalid = 1'b0;
    s_bus.rvalid = 1'b1; s_bus.rlast = 1'b1; s_bus.rdata = 32'h0000_00AA;
    @(negedge clk);
    checkOutput("post_rst_m0_data", {m0_bus.rvalid, m1_bus.rvalid}, 2'b10);
    step();
    s_bus.rvalid = 1'b0; s_bus.rlast = 1'b0; s_bus.arready = 1'b0;
    @(negedge clk);
    checkOutput("release_idle", s_bus.arvalid, 1'b0);

    // Pending m1 read stalled by s_arready=0 for five cycles, accepted on the sixth.
    for (int c = 1; c <= 5; c++) begin
      step();
      @(negedge clk);
      checkOutput("stall_flags", {s_bus.arvalid, m1_bus.arready, m0_bus.arready}, 3'b100);
      checkOutput("stall_araddr", s_bus.araddr, A1);
    end
    step();
    s_bus.arready = 1'b1;
    @(negedge clk);
    checkOutput("stall_accept", {s_bus.arvalid, m1_bus.arready}, 2'b11);
    step();
    m1_bus.arvalid = 1'b0;
    s_bus.rvalid = 1'b1; s_bus.rlast = 1'b1; s_bus.rdata = 32'h600D_F00D; s_bus.rid = 4'h7;
    @(negedge clk);
    checkOutput("m1_r_route", {m1_bus.rvalid, m0_bus.rvalid}, 2'b10);
    checkOutput("m1_r_data", m1_bus.rdata, 32'h600D_F00D);
    checkOutput("m1_r_id", m1_bus.rid, 4'h7);
    step();
    s_bus.rvalid = 1'b0; s_bus.rlast = 1'b0;
    @(negedge clk);
    checkOutput("final_idle", {s_bus.arvalid, s_bus.rready, m1_bus.rvalid}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
